// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the multicycle controller: opcode and
//                funct constants, the FSM state enum, datapath mux and
//                alu_op encodings, write-enable bit positions and the decode
//                record handed from ctrl_decode to the FSM.
//  Options     : MULTICYCLE_CTRL_MULTDIV_EN adds the MD_START/MD_WAIT states.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Primary opcodes (instruction bits 31:26)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instruction bits 5:0)
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    // Write-enable bit positions within wr_en
    localparam int WR_PC     = 6;
    localparam int WR_A      = 5;
    localparam int WR_B      = 4;
    localparam int WR_ALUOUT = 3;
    localparam int WR_MEM    = 2;
    localparam int WR_IR     = 1;
    localparam int WR_REG    = 0;

    // Memory address mux
    localparam logic [2:0] MA_PC     = 3'b000;
    localparam logic [2:0] MA_ALUOUT = 3'b001;

    // ALU operand A mux
    localparam logic [1:0] SA_PC = 2'b00;
    localparam logic [1:0] SA_A  = 2'b01;

    // ALU operand B mux
    localparam logic [2:0] SB_B       = 3'b000;
    localparam logic [2:0] SB_FOUR    = 3'b001;
    localparam logic [2:0] SB_IMM     = 3'b010;
    localparam logic [2:0] SB_IMM_SH2 = 3'b011;

    // ALU operation
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    // PC source mux
    localparam logic [1:0] PS_ALU    = 2'b00;
    localparam logic [1:0] PS_ALUOUT = 2'b01;
    localparam logic [1:0] PS_JUMP   = 2'b10;
    localparam logic [1:0] PS_EXC    = 2'b11;

    // Register destination mux
    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R29 = 2'b11;

    // Register write-data mux
    localparam logic [2:0] WD_ALUOUT = 3'b000;
    localparam logic [2:0] WD_MDR    = 3'b001;
    localparam logic [2:0] WD_C227   = 3'b011;
    localparam logic [2:0] WD_HI     = 3'b100;
    localparam logic [2:0] WD_LO     = 3'b101;

    typedef enum logic [4:0] {
        ST_RESET    = 5'd0,
        ST_FETCH    = 5'd1,
        ST_DECODE   = 5'd2,
        ST_EXEC_R   = 5'd3,
        ST_EXEC_I   = 5'd4,
        ST_MEM_ADDR = 5'd5,
        ST_MEM_RD   = 5'd6,
        ST_MEM_WB   = 5'd7,
        ST_MEM_WR   = 5'd8,
        ST_WB       = 5'd9,
        ST_BRANCH   = 5'd10,
        ST_JUMP     = 5'd11,
        ST_EXC      = 5'd12
`ifdef MULTICYCLE_CTRL_MULTDIV_EN
        ,
        ST_MD_START = 5'd13,
        ST_MD_WAIT  = 5'd14
`endif
    } state_t;

    // Per-instruction attributes captured at DECODE and used by later states
    typedef struct packed {
        logic [2:0] alu_op;   // EXEC_R operation
        logic       ovf_chk;  // overflow traps (add/sub/addi)
        logic       is_r;     // write rd instead of rt
        logic       is_sw;    // MEM_ADDR goes to MEM_WR
        logic       is_bne;   // branch on !zero
        logic       md_op;    // 0 mult, 1 div
        logic [2:0] wd_sel;   // WB write-data source
    } dec_info_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Combinational instruction decoder. Maps opcode/funct to the
//                state DECODE dispatches to, a valid flag (0 -> exception),
//                and the attributes the later states need.
//  Ports       : i_opcode  instruction bits 31:26
//                i_funct   instruction bits 5:0
//                o_target  dispatch state (ST_EXC when invalid)
//                o_valid   instruction recognised
//                o_info    per-instruction attributes
//  Options     : MULTICYCLE_CTRL_MULTDIV_EN decodes mult/div/mfhi/mflo.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output state_t     o_target,
    output logic       o_valid,
    output dec_info_t  o_info
);

    always_comb begin
        o_target = ST_EXC;
        o_valid  = 1'b0;
        o_info   = '0;
        case (i_opcode)
            OP_RTYPE: begin
                o_info.is_r = 1'b1;
                case (i_funct)
                    FN_ADD: begin
                        o_target       = ST_EXEC_R;
                        o_valid        = 1'b1;
                        o_info.alu_op  = ALU_ADD;
                        o_info.ovf_chk = 1'b1;
                    end
                    FN_SUB: begin
                        o_target       = ST_EXEC_R;
                        o_valid        = 1'b1;
                        o_info.alu_op  = ALU_SUB;
                        o_info.ovf_chk = 1'b1;
                    end
                    FN_AND: begin
                        o_target      = ST_EXEC_R;
                        o_valid       = 1'b1;
                        o_info.alu_op = ALU_AND;
                    end
`ifdef MULTICYCLE_CTRL_MULTDIV_EN
                    FN_MULT, FN_DIV: begin
                        o_target     = ST_MD_START;
                        o_valid      = 1'b1;
                        o_info.md_op = (i_funct == FN_DIV);
                    end
                    // mfhi/mflo need no ALU work: straight to the register write
                    FN_MFHI: begin
                        o_target      = ST_WB;
                        o_valid       = 1'b1;
                        o_info.wd_sel = WD_HI;
                    end
                    FN_MFLO: begin
                        o_target      = ST_WB;
                        o_valid       = 1'b1;
                        o_info.wd_sel = WD_LO;
                    end
`endif
                    default: ;
                endcase
            end
            OP_ADDI: begin
                o_target       = ST_EXEC_I;
                o_valid        = 1'b1;
                o_info.alu_op  = ALU_ADD;
                o_info.ovf_chk = 1'b1;
            end
            OP_LW: begin
                o_target = ST_MEM_ADDR;
                o_valid  = 1'b1;
            end
            OP_SW: begin
                o_target     = ST_MEM_ADDR;
                o_valid      = 1'b1;
                o_info.is_sw = 1'b1;
            end
            OP_BEQ: begin
                o_target = ST_BRANCH;
                o_valid  = 1'b1;
            end
            OP_BNE: begin
                o_target      = ST_BRANCH;
                o_valid       = 1'b1;
                o_info.is_bne = 1'b1;
            end
            OP_J: begin
                o_target = ST_JUMP;
                o_valid  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM for a multicycle MIPS-style datapath. Sequences
//                fetch, decode, execute, memory and write-back, with a wait
//                counter stretching FETCH and MEM_RD over MEM_LAT cycles.
//  Parameters  : MEM_LAT  memory read latency in cycles (1..7)
//                CNT_W    wait counter width (2**CNT_W > MEM_LAT)
//  Ports       : clk, reset (async, active-low)
//                opcode/funct      instruction fields from IR
//                overflow/zero     ALU flags
//                md_done           mult/div unit finished
//                wr_en             {PC,A,B,ALUOut,Mem,IR,Reg}
//                mem_addr_sel, alu_src_a, alu_src_b, alu_op, pc_src,
//                reg_dst, wd_sel   datapath mux/ALU controls
//                md_start, md_op   mult/div start pulse and operation
//                epc_we            EPC write enable
//                state_o           current state (debug)
//  Options     : MULTICYCLE_CTRL_MULTDIV_EN enables mult/div/mfhi/mflo.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    input  logic       md_done,
    output logic [6:0] wr_en,
    output logic [2:0] mem_addr_sel,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [2:0] wd_sel,
    output logic       md_start,
    output logic       md_op,
    output logic       epc_we,
    output logic [4:0] state_o
);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    dec_info_t         r_info;
    state_t            w_target;
    logic              w_valid;
    dec_info_t         w_info;
    logic              w_cnt_last;

    ctrl_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_target (w_target),
        .o_valid  (w_valid),
        .o_info   (w_info)
    );

    assign w_cnt_last = (r_cnt == CNT_W'(MEM_LAT - 1));
    assign state_o    = r_state;

    // Counter restarts at 0 whenever the state changes, so every multi-cycle
    // state sees a fresh count from its first cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
            r_info  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (r_state == ST_DECODE) begin
                r_info <= w_info;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        wr_en        = '0;
        mem_addr_sel = MA_PC;
        alu_src_a    = SA_PC;
        alu_src_b    = SB_B;
        alu_op       = '0;
        pc_src       = PS_ALU;
        reg_dst      = RD_RT;
        wd_sel       = WD_ALUOUT;
        md_start     = 1'b0;
        md_op        = 1'b0;
        epc_we       = 1'b0;
        // Outputs are gated by reset so they drop to 0 the moment reset
        // asserts, not at the next clock.
        if (reset) begin
            case (r_state)
                ST_RESET: begin
                    wr_en[WR_REG] = 1'b1;
                    reg_dst       = RD_R29;
                    wd_sel        = WD_C227;
                    w_next        = ST_FETCH;
                end
                ST_FETCH: begin
                    mem_addr_sel = MA_PC;
                    alu_src_a    = SA_PC;
                    alu_src_b    = SB_FOUR;
                    alu_op       = ALU_ADD;
                    if (w_cnt_last) begin
                        wr_en[WR_PC] = 1'b1;
                        wr_en[WR_IR] = 1'b1;
                        pc_src       = PS_ALU;
                        w_next       = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    wr_en[WR_A]      = 1'b1;
                    wr_en[WR_B]      = 1'b1;
                    wr_en[WR_ALUOUT] = 1'b1;
                    alu_src_a        = SA_PC;
                    alu_src_b        = SB_IMM_SH2;
                    alu_op           = ALU_ADD;
                    w_next           = w_valid ? w_target : ST_EXC;
                end
                ST_EXEC_R, ST_EXEC_I: begin
                    wr_en[WR_ALUOUT] = 1'b1;
                    alu_src_a        = SA_A;
                    alu_src_b        = (r_state == ST_EXEC_R) ? SB_B : SB_IMM;
                    alu_op           = (r_state == ST_EXEC_R) ? r_info.alu_op : ALU_ADD;
                    w_next           = (r_info.ovf_chk && overflow) ? ST_EXC : ST_WB;
                end
                ST_MEM_ADDR: begin
                    wr_en[WR_ALUOUT] = 1'b1;
                    alu_src_a        = SA_A;
                    alu_src_b        = SB_IMM;
                    alu_op           = ALU_ADD;
                    w_next           = r_info.is_sw ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    mem_addr_sel = MA_ALUOUT;
                    if (w_cnt_last) begin
                        w_next = ST_MEM_WB;
                    end
                end
                ST_MEM_WB: begin
                    wr_en[WR_REG] = 1'b1;
                    wd_sel        = WD_MDR;
                    reg_dst       = RD_RT;
                    w_next        = ST_FETCH;
                end
                ST_MEM_WR: begin
                    wr_en[WR_MEM] = 1'b1;
                    mem_addr_sel  = MA_ALUOUT;
                    w_next        = ST_FETCH;
                end
                ST_WB: begin
                    wr_en[WR_REG] = 1'b1;
                    wd_sel        = r_info.wd_sel;
                    reg_dst       = r_info.is_r ? RD_RD : RD_RT;
                    w_next        = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_src_a    = SA_A;
                    alu_src_b    = SB_B;
                    alu_op       = ALU_SUB;
                    pc_src       = PS_ALUOUT;
                    wr_en[WR_PC] = r_info.is_bne ? !zero : zero;
                    w_next       = ST_FETCH;
                end
                ST_JUMP: begin
                    wr_en[WR_PC] = 1'b1;
                    pc_src       = PS_JUMP;
                    w_next       = ST_FETCH;
                end
                ST_EXC: begin
                    epc_we       = 1'b1;
                    wr_en[WR_PC] = 1'b1;
                    pc_src       = PS_EXC;
                    w_next       = ST_FETCH;
                end
`ifdef MULTICYCLE_CTRL_MULTDIV_EN
                ST_MD_START: begin
                    md_start = 1'b1;
                    md_op    = r_info.md_op;
                    w_next   = ST_MD_WAIT;
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        w_next = ST_FETCH;
                    end
                end
`endif
                default: w_next = ST_RESET;
            endcase
        end
    end

`ifndef MULTICYCLE_CTRL_MULTDIV_EN
    // Mult/div support is compiled out; these inputs have no consumer.
    logic w_unused_md;
    assign w_unused_md = md_done ^ r_info.md_op;
`endif

endmodule : multicycle_ctrl
`default_nettype wire
